// File: rtl/neuron_driver_pkg.sv
// Shared defaults, configuration address codes and class threshold for the neuron driver.
package neuron_driver_pkg;

    localparam int unsigned DefaultWidth     = 16;
    localparam int unsigned DefaultFrac      = 8;
    localparam int unsigned DefaultNeuronLat = 3;
    localparam int unsigned DefaultDepth     = 4;

    typedef enum logic [1:0] {
        CfgWeight1  = 2'd0,
        CfgWeight2  = 2'd1,
        CfgBias     = 2'd2,
        CfgReserved = 2'd3
    } cfg_addr_e;

    // 0.5 in Q8.8: results at or above this are class 1.
    localparam logic [DefaultWidth-1:0] DefaultThreshold =
        DefaultWidth'(1) << (DefaultFrac - 1);

endpackage

// File: rtl/neuron_result_fifo.sv
// Synchronous result FIFO with modulo-DEPTH pointers and an occupancy count.
module neuron_result_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CntW-1:0]  count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CntW'(DEPTH)) || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/neuron_driver.sv
// Neuron driver: issues registered operands to an external fixed-latency neuron and
// collects its results, in order, in a credit-protected FIFO.
module neuron_driver
    import neuron_driver_pkg::*;
#(
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter int unsigned FRAC       = DefaultFrac,
    parameter int unsigned NEURON_LAT = DefaultNeuronLat,
    parameter int unsigned DEPTH      = DefaultDepth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x1,
    input  logic [WIDTH-1:0] in_x2,
    output logic [WIDTH-1:0] n_input1,
    output logic [WIDTH-1:0] n_input2,
    output logic [WIDTH-1:0] n_weight1,
    output logic [WIDTH-1:0] n_weight2,
    output logic [WIDTH-1:0] n_bias,
    input  logic [WIDTH-1:0] n_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_class,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned SumW = CntW + 1;
    localparam logic [WIDTH-1:0] Threshold = WIDTH'(1) << (FRAC - 1);

    logic [WIDTH-1:0]    weight1_q, weight2_q, bias_q;
    logic [NEURON_LAT:0] tag_q, tag_d;
    logic [CntW-1:0]     outstanding_q, outstanding_d;
    logic [CntW-1:0]     fifo_count;
    logic [WIDTH:0]      fifo_wdata, fifo_rdata;
    logic                accept, push, pop, result_class;

    assign accept = in_valid && in_ready;
    assign push   = tag_q[NEURON_LAT];
    assign pop    = out_valid && out_ready;

    // Credits cover in-flight plus buffered results, so a push always finds room.
    assign in_ready  = rst_n && ((SumW'(outstanding_q) + SumW'(fifo_count)) < SumW'(DEPTH));
    assign out_valid = (fifo_count != '0);
    assign busy      = (outstanding_q != '0) || (fifo_count != '0);

    assign result_class = ($signed(n_result) >= $signed(Threshold));
    assign fifo_wdata   = {result_class, n_result};
    assign out_class    = fifo_rdata[WIDTH];
    assign out_data     = fifo_rdata[WIDTH-1:0];

    always_comb begin
        tag_d         = tag_q << 1;
        tag_d[0]      = accept;
        outstanding_d = outstanding_q;
        if (accept && !push) begin
            outstanding_d = outstanding_q + CntW'(1);
        end else if (!accept && push) begin
            outstanding_d = outstanding_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight1_q     <= '0;
            weight2_q     <= '0;
            bias_q        <= '0;
            n_input1      <= '0;
            n_input2      <= '0;
            n_weight1     <= '0;
            n_weight2     <= '0;
            n_bias        <= '0;
            tag_q         <= '0;
            outstanding_q <= '0;
        end else begin
            tag_q         <= tag_d;
            outstanding_q <= outstanding_d;
            if (cfg_we) begin
                case (cfg_addr_e'(cfg_addr))
                    CfgWeight1: weight1_q <= cfg_data;
                    CfgWeight2: weight2_q <= cfg_data;
                    CfgBias:    bias_q    <= cfg_data;
                    default:    ;
                endcase
            end
            // Operands sample the pre-edge config, so a same-edge write applies next time.
            if (accept) begin
                n_input1  <= in_x1;
                n_input2  <= in_x2;
                n_weight1 <= weight1_q;
                n_weight2 <= weight2_q;
                n_bias    <= bias_q;
            end
        end
    end

    neuron_result_fifo #(
        .WIDTH(WIDTH + 1),
        .DEPTH(DEPTH)
    ) u_result_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .wdata(fifo_wdata),
        .pop  (pop),
        .rdata(fifo_rdata),
        .count(fifo_count)
    );

endmodule

// File: tb/tb_neuron_driver.sv
// Bench for neuron_driver: external 3-cycle sigmoid-LUT neuron, scoreboard model,
// table vectors, hand-written corner sequences and a randomized phase.
module tb_neuron_driver;

    localparam int DEPTH = 4;

    logic        clk, rst_n, cfg_we, in_valid, in_ready, out_valid, out_ready, out_class, busy;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data, in_x1, in_x2, n_result, out_data;
    logic [15:0] n_input1, n_input2, n_weight1, n_weight2, n_bias;

    neuron_driver #(
        .WIDTH(16),
        .FRAC(8),
        .NEURON_LAT(3),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1), .in_x2(in_x2),
        .n_input1(n_input1), .n_input2(n_input2), .n_weight1(n_weight1),
        .n_weight2(n_weight2), .n_bias(n_bias), .n_result(n_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_class(out_class), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q8.8 neuron: x = x1*w1 + x2*w2 + b, then a coarse sigmoid lookup.
    function automatic logic [15:0] neuron(input logic [15:0] a1, w1, a2, w2, b);
        int p1, p2, x;
        p1 = int'($signed(a1)) * int'($signed(w1));
        p2 = int'($signed(a2)) * int'($signed(w2));
        x  = (p1 >>> 8) + (p2 >>> 8) + int'($signed(b));
        if (x <= -512)     return 16'h0000;
        else if (x <= -256) return 16'h0049;
        else if (x <= 0)    return 16'h0080;
        else if (x <= 256)  return 16'h00B7;
        else                return 16'h0100;
    endfunction

    logic [15:0] s1, s2, s3;
    always @(posedge clk) begin
        s1 <= neuron(n_input1, n_weight1, n_input2, n_weight2, n_bias);
        s2 <= s1;
        s3 <= s2;
    end
    assign n_result = s3;

    // Scoreboard: samples in flight with their due edge, then buffered results.
    typedef struct { int due; logic [15:0] data; } flight_t;
    flight_t     inflight[$];
    logic [15:0] fifo_m[$];
    logic [15:0] popped[$];
    logic [15:0] m_w1, m_w2, m_bias;
    int          cyc, n_tests, n_fail;
    logic        dut_acc, post_valid, post_class;
    logic [15:0] post_data;

    typedef struct { logic [15:0] x1, x2, data; logic cls; } vec_t;
    vec_t        tbl[10];
    logic [15:0] xs[4];
    logic [15:0] exp_s[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_empty();
        return (inflight.size() == 0) && (fifo_m.size() == 0);
    endfunction

    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic ord, input logic we = 1'b0, input logic [1:0] ad = 2'd0,
                        input logic [15:0] d = 16'd0, input logic rn = 1'b1);
        logic        exp_ready, acc, pop;
        logic [15:0] ow1, ow2, ob;
        in_valid  = v;
        in_x1     = a;
        in_x2     = b;
        out_ready = ord;
        cfg_we    = we;
        cfg_addr  = ad;
        cfg_data  = d;
        rst_n     = rn;
        #1;
        exp_ready = rn && ((inflight.size() + fifo_m.size()) < DEPTH);
        chk("in_ready", in_ready, exp_ready);
        if (rn) begin
            chk("out_valid", out_valid, fifo_m.size() != 0);
            chk("busy", busy, !model_empty());
            if (fifo_m.size() != 0) begin
                chk("out_data", out_data, fifo_m[0]);
                chk("out_class", out_class, $signed(fifo_m[0]) >= $signed(16'h0080));
            end
            if (out_valid && ord) popped.push_back(out_data);
        end
        dut_acc = v && in_ready;
        acc     = v && exp_ready;
        pop     = rn && ord && (fifo_m.size() != 0);
        ow1 = m_w1; ow2 = m_w2; ob = m_bias;
        @(posedge clk);
        cyc++;
        if (!rn) begin
            inflight.delete();
            fifo_m.delete();
            m_w1 = '0; m_w2 = '0; m_bias = '0;
        end else begin
            if (pop) void'(fifo_m.pop_front());
            if (inflight.size() != 0 && inflight[0].due == cyc) begin
                fifo_m.push_back(inflight[0].data);
                void'(inflight.pop_front());
            end
            if (acc) inflight.push_back('{cyc + 4, neuron(a, ow1, b, ow2, ob)});
            if (we) begin
                case (ad)
                    2'd0:    m_w1 = d;
                    2'd1:    m_w2 = d;
                    2'd2:    m_bias = d;
                    default: ;
                endcase
            end
        end
        #1;
        post_valid = out_valid;
        post_data  = out_data;
        post_class = out_class;
        if (acc) begin
            chk("n_input1", n_input1, a);
            chk("n_input2", n_input2, b);
            chk("n_weight1", n_weight1, ow1);
            chk("n_weight2", n_weight2, ow2);
            chk("n_bias", n_bias, ob);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 32 && !model_empty(); i++) step(1'b0, 16'd0, 16'd0, 1'b1);
        chk("drained", model_empty(), 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_n_input1"}, n_input1, 0);
        chk({tag, "_n_input2"}, n_input2, 0);
        chk({tag, "_n_weight1"}, n_weight1, 0);
        chk({tag, "_n_weight2"}, n_weight2, 0);
        chk({tag, "_n_bias"}, n_bias, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_class"}, out_class, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic configure();
        step(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 2'd0, 16'h0100);
        step(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 2'd1, 16'h0100);
        step(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 2'd2, 16'hFF00);
    endtask

    initial begin
        int          lat, nacc, nsent;
        logic        found, cls;
        logic [15:0] dat, rx1, rx2, rd;
        n_tests = 0; n_fail = 0; cyc = 0;
        m_w1 = '0; m_w2 = '0; m_bias = '0;
        tbl[0] = '{16'h0100, 16'h0100, 16'h00B7, 1'b1};
        tbl[1] = '{16'h0000, 16'h0000, 16'h0049, 1'b0};
        tbl[2] = '{16'h0080, 16'h0080, 16'h0080, 1'b1};
        tbl[3] = '{16'h0100, 16'h0000, 16'h0080, 1'b1};
        tbl[4] = '{16'hFF80, 16'h0000, 16'h0049, 1'b0};
        tbl[5] = '{16'h0180, 16'h0000, 16'h00B7, 1'b1};
        tbl[6] = '{16'h0200, 16'h0100, 16'h0100, 1'b1};
        tbl[7] = '{16'hFF00, 16'hFF00, 16'h0000, 1'b0};
        tbl[8] = '{16'h0001, 16'h0000, 16'h0080, 1'b1};
        tbl[9] = '{16'hFF00, 16'h0000, 16'h0000, 1'b0};
        xs[0] = 16'hFF00; xs[1] = 16'hFF80; xs[2] = 16'h0080; xs[3] = 16'h0180;
        exp_s[0] = 16'h0000; exp_s[1] = 16'h0049; exp_s[2] = 16'h0080; exp_s[3] = 16'h00B7;

        // Reset, then the first edge after release must accept.
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
        check_all_zero("reset");
        step(1'b1, 16'h0100, 16'h0100, 1'b1);
        chk("first_accept", dut_acc, 1'b1);
        drain();
        configure();

        // Table vectors: one sample at a time, latency and value from the table.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i].x1, tbl[i].x2, 1'b1);
            found = 1'b0; lat = 0; dat = '0; cls = 1'b0;
            for (int c = 1; c <= 8 && !found; c++) begin
                step(1'b0, 16'd0, 16'd0, 1'b1);
                if (post_valid) begin
                    found = 1'b1; lat = c; dat = post_data; cls = post_class;
                end
            end
            chk("tbl_latency", lat, 4);
            chk("tbl_data", dat, tbl[i].data);
            chk("tbl_class", cls, tbl[i].cls);
        end
        drain();

        // Stalled output: only DEPTH accepts, then an in-order drain.
        popped.delete();
        nacc = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, xs[c % 4], 16'd0, 1'b0);
            if (dut_acc) nacc++;
        end
        chk("stall_accepts", nacc, 4);
        chk("stall_ready", in_ready, 1'b0);
        drain();
        chk("stall_drain_count", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) chk("stall_order", popped[i], exp_s[i]);

        // Streaming 16 samples with the output always ready.
        popped.delete();
        nsent = 0;
        for (int c = 0; c < 80 && (nsent < 16 || !model_empty()); c++) begin
            step(nsent < 16, xs[nsent % 4], 16'd0, 1'b1);
            if (dut_acc) nsent++;
        end
        chk("stream_sent", nsent, 16);
        chk("stream_out_count", popped.size(), 16);
        for (int i = 0; i < 16 && i < popped.size(); i++) chk("stream_order", popped[i], exp_s[i % 4]);

        // Config write on the same edge as an accept applies only to the next sample.
        popped.delete();
        step(1'b1, 16'd0, 16'd0, 1'b1, 1'b1, 2'd2, 16'h0000);
        chk("bias_old", n_bias, 16'hFF00);
        step(1'b1, 16'd0, 16'd0, 1'b1);
        chk("bias_new", n_bias, 16'h0000);
        drain();
        chk("bias_count", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("bias_old_result", popped[0], 16'h0049);
            chk("bias_new_result", popped[1], 16'h0080);
        end
        step(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 2'd3, 16'h1234);
        step(1'b1, 16'd0, 16'd0, 1'b1);
        chk("reserved_ignored", n_bias, 16'h0000);
        drain();

        // Reset with three samples outstanding discards them.
        configure();
        for (int i = 0; i < 3; i++) step(1'b1, xs[i], 16'd0, 1'b1);
        chk("pre_reset_busy", busy, 1'b1);
        step(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0);
        check_all_zero("midreset");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'd0, 16'd0, 1'b1);
            chk("post_reset_no_valid", post_valid, 1'b0);
        end

        // Randomized traffic, config writes and backpressure.
        configure();
        for (int c = 0; c < 400; c++) begin
            rx1 = 16'($urandom_range(0, 1023)) - 16'd512;
            rx2 = 16'($urandom_range(0, 1023)) - 16'd512;
            rd  = 16'($urandom_range(0, 768)) - 16'd384;
            step($urandom_range(0, 3) != 0, rx1, rx2, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)), rd);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
